// File: rtl/instr_fetch_decode.sv
// Instruction fetch and field decode: requests a word from instruction memory,
// retries on timeout, and holds the decoded fields while the PC is unchanged.
module instr_fetch_decode #(
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [6:0]  op,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [1:0]  funct2,
  output logic [6:0]  funct7,
  output logic [11:0] imm12,
  output logic [19:0] immhi,
  output logic        instr_valid,
  output logic        illegal_op,
  output logic        fetch_err
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  // IDLE doubles as the one-cycle request gap between a timeout and the retry.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   cur_pc_q, cur_pc_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [WW-1:0] wait_cnt_inc;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic [31:0]   ir_q, ir_d;
  logic          illegal_q, illegal_d;
  logic          data_legal;

  always_comb begin
    data_legal = 1'b0;
    case (imem_data[6:0])
      7'b0000011, 7'b0010011, 7'b0110011, 7'b0110111: data_legal = 1'b1;
      default:                                        data_legal = 1'b0;
    endcase
  end

  assign wait_cnt_inc = wait_cnt_q + WW'(1);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cur_pc_d    = cur_pc_q;
    wait_cnt_d  = wait_cnt_q;
    retry_cnt_d = retry_cnt_q;
    ir_d        = ir_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        cur_pc_d   = pc_in;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          ir_d        = imem_data;
          illegal_d   = ~data_legal;
          wait_cnt_d  = '0;
          retry_cnt_d = '0;
          state_d     = S_HOLD;
        end else if (wait_cnt_inc == WW'(TIMEOUT)) begin
          wait_cnt_d = '0;
          if (retry_cnt_q == RW'(RETRY_MAX)) begin
            state_d = S_ERR;
          end else begin
            retry_cnt_d = retry_cnt_q + RW'(1);
            state_d     = S_IDLE;
          end
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      S_HOLD:  if (pc_in != cur_pc_q) state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_pc_q    <= '0;
      wait_cnt_q  <= '0;
      retry_cnt_q <= '0;
      ir_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_pc_q    <= cur_pc_d;
      wait_cnt_q  <= wait_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      ir_q        <= ir_d;
      illegal_q   <= illegal_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign imem_addr = (state_q == S_FETCH) ? pc_in :
                     (state_q == S_WAIT)  ? cur_pc_q : 32'd0;

  // Valid drops combinationally the moment pc_in moves, so a stale word is never flagged usable.
  assign instr_valid = (state_q == S_HOLD) && (pc_in == cur_pc_q);
  assign illegal_op  = illegal_q;
  assign fetch_err   = (state_q == S_ERR);

  assign op     = (instr_valid && !illegal_q) ? ir_q[6:0] : 7'd0;
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct2 = ir_q[26:25];
  assign funct7 = ir_q[31:25];
  assign imm12  = ir_q[31:20];
  assign immhi  = ir_q[31:12];

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of cycles to wait for imem_ack before a retry.
REQ-002 SHALL have parameter RETRY_MAX, default 3, the number of retries before fetch_err is raised.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- pc_in  in  32  word-addressed program counter from the controller's PCout.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  instruction word address.
- imem_ack  in  1  memory response valid; imem_data is sampled on the same cycle.
- imem_data  in  32  fetched instruction.
- op  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- funct3  out  3  instr[14:12].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct2  out  2  instr[26:25].
- funct7  out  7  instr[31:25].
- imm12  out  12  instr[31:20].
- immhi  out  20  instr[31:12].
- instr_valid  out  1  decoded fields are stable and usable.
- illegal_op  out  1  the latched opcode is unsupported.
- fetch_err  out  1  sticky flag: retries exhausted.

Function
REQ-004 SHALL implement states IDLE, FETCH, WAIT, HOLD, ERR.
REQ-005 IDLE SHALL move to FETCH on the first clock after rst deasserts.
REQ-006 In FETCH, the block SHALL:
- capture cur_pc <= pc_in;
- assert imem_req=1 and imem_addr=pc_in;
- go to WAIT on the next edge.
REQ-007 In WAIT, the block SHALL hold imem_req=1 with imem_addr=cur_pc and increment a wait counter each cycle.
REQ-008 imem_ack in WAIT SHALL cause the following on that edge:
- latch imem_data into the instruction register;
- clear the wait counter and retry counter;
- go to HOLD;
- deassert imem_req.
REQ-009 The wait counter reaching TIMEOUT without ack SHALL cause the following:
- deassert imem_req for one cycle;
- increment the retry counter;
- return to FETCH.
REQ-010 When the retry counter would exceed RETRY_MAX, the block SHALL go to ERR, set fetch_err=1 and hold imem_req=0.
REQ-011 In HOLD, instr_valid SHALL be 1 and all decoded fields SHALL be held constant.
REQ-012 In HOLD, the block SHALL return to FETCH with instr_valid=0 when pc_in != cur_pc.
REQ-013 pc_in changing during WAIT SHALL NOT cancel the request. The ack data SHALL be latched, and HOLD then immediately refetches on the following cycle with instr_valid=0 (instr_valid pulses 0; it is never 1 for a stale PC).
REQ-014 imem_ack outside WAIT SHALL be ignored.
REQ-015 Decoded field outputs SHALL be pure bit-slices of the instruction register, with no sign extension (sign extension belongs to the consumer).
REQ-016 Legal opcodes SHALL be 0000011, 0010011, 0110011 and 0110111; any other latched opcode SHALL have the following effect:
- set illegal_op=1;
- force op=0000000 so the controller idles;
- still assert instr_valid=1 in HOLD.
REQ-017 instr_valid=0 SHALL force op=0, so no opcode is ever presented without instr_valid.
REQ-018 Fetch latency from entering FETCH to instr_valid=1 SHALL be 2 cycles plus the memory wait (ack in the first WAIT cycle gives instr_valid on cycle 3).
REQ-019 ERR SHALL be left only by rst.

Reset
REQ-020 rst=1 SHALL immediately, without a clock, force the following:
- state IDLE;
- imem_req=0, imem_addr=0;
- instruction register 0, so all decoded outputs are 0;
- instr_valid=0, illegal_op=0, fetch_err=0;
- cur_pc, wait counter and retry counter all 0.
REQ-021 rst asserted mid-WAIT SHALL abandon the request, and an imem_ack arriving while rst=1 SHALL be ignored.
REQ-022 After rst deasserts, the first fetch SHALL use the pc_in present in FETCH.

Verification
REQ-023 pc_in=0, ack on the first WAIT cycle with data 0x00500093 -> imem_addr=0, op=0010011, rd=1, rs1=0, funct3=0, imm12=0x005, instr_valid=1 on cycle 3.
REQ-024 In HOLD, pc_in 0->1 -> instr_valid=0 next cycle, imem_req=1 with imem_addr=1; data 0x40208133 -> op=0110011, funct7=0100000, rs2=2, rs1=1, rd=2.
REQ-025 Data 0x0000007F -> illegal_op=1, op=0, instr_valid=1; next legal fetch -> illegal_op=0.
REQ-026 With TIMEOUT=4, RETRY_MAX=3 and no ack -> imem_req pattern 5 high / 1 low repeated 4 times, then fetch_err=1 and imem_req=0 permanently.
REQ-027 pc_in changes during WAIT, ack with 0x12345037 -> instr_valid stays 0 and a refetch issues at the new pc_in; lui fields (immhi=0x12345, rd=0) are checked after the refetch.
REQ-028 rst pulsed mid-WAIT with a simultaneous ack -> all outputs 0 while rst=1, the instruction register is not updated, and the fetch restarts after release.
